// File: rtl/dvbs2_bit_mapper_ram_responder_if.sv
// Signal bundle between the TX register file / bit mapper and the
// bit_mapper_ram responder.
//   Bus port    : bit_mapper_ram_addr/wdata/wen (to responder), bit_mapper_ram_rdata (back)
//   Lookup req  : s_tvalid/s_taddr/s_tid (to responder), s_tready (back)
//   Lookup resp : m_tvalid/m_tdata/m_tid (from responder), m_tready (to responder)
// master modport = requester side, slave modport = responder side.
interface dvbs2_bit_mapper_ram_responder_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH  = 4
) ();
  logic [ADDR_WIDTH-1:0]   bit_mapper_ram_addr;
  logic [DATA_WIDTH-1:0]   bit_mapper_ram_wdata;
  logic [DATA_WIDTH/8-1:0] bit_mapper_ram_wen;
  logic [DATA_WIDTH-1:0]   bit_mapper_ram_rdata;

  logic                    s_tvalid;
  logic                    s_tready;
  logic [ADDR_WIDTH-1:0]   s_taddr;
  logic [TID_WIDTH-1:0]    s_tid;

  logic                    m_tvalid;
  logic                    m_tready;
  logic [DATA_WIDTH-1:0]   m_tdata;
  logic [TID_WIDTH-1:0]    m_tid;

  modport master (
    output bit_mapper_ram_addr, bit_mapper_ram_wdata, bit_mapper_ram_wen,
    input  bit_mapper_ram_rdata,
    output s_tvalid, s_taddr, s_tid,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tid,
    output m_tready
  );

  modport slave (
    input  bit_mapper_ram_addr, bit_mapper_ram_wdata, bit_mapper_ram_wen,
    output bit_mapper_ram_rdata,
    input  s_tvalid, s_taddr, s_tid,
    output s_tready,
    output m_tvalid, m_tdata, m_tid,
    input  m_tready
  );
endinterface

// File: rtl/dvbs2_bit_mapper_ram_responder.sv
// User-logic end of the register file's bit_mapper_ram memory interface.
// Holds the DEPTH x DATA_WIDTH constellation table as true dual-port storage:
//   - bus port (register file): byte-enabled writes, reads every cycle with
//     1-cycle latency, read-before-write, out-of-range reads return 0 and
//     out-of-range writes are dropped.
//   - lookup port (bit mapper): valid/ready request stream -> one RAM-read
//     stage P -> 2-entry output FIFO -> valid/ready response stream, in order,
//     tag echoed. Out-of-range lookups answer 0 and set the sticky oob_error.
// Ports:
//   axi_aclk     clock
//   axi_aresetn  asynchronous active-low reset (table contents are kept)
//   bus          slave modport of dvbs2_bit_mapper_ram_responder_if
//   oob_error    sticky flag: some lookup addressed >= DEPTH
// Build option: define DVBS2_BIT_MAPPER_RAM_WRITE_FWD_EN to forward a same-cycle
// bus write (byte-merged) into a colliding lookup; otherwise the lookup sees
// the old word.
module dvbs2_bit_mapper_ram_responder #(
  parameter int unsigned DEPTH      = 240,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TID_WIDTH  = 4
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_aresetn,
  dvbs2_bit_mapper_ram_responder_if.slave        bus,
  output logic                                   oob_error
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] byte_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                       input logic [DATA_WIDTH-1:0] new_word,
                                                       input logic [NumBytes-1:0]   be);
    logic [DATA_WIDTH-1:0] m;
    m = old_word;
    for (int b = 0; b < NumBytes; b++) begin
      if (be[b]) m[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Bus port
  logic                  bus_in_range;
  logic                  bus_wr;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign bus_in_range = {1'b0, bus.bit_mapper_ram_addr} < DepthLim;
  assign bus_wr       = (|bus.bit_mapper_ram_wen) && bus_in_range;

  // Storage is deliberately not reset so the table survives axi_aresetn.
  always_ff @(posedge axi_aclk) begin
    if (bus_wr) begin
      mem[bus.bit_mapper_ram_addr] <= byte_merge(mem[bus.bit_mapper_ram_addr],
                                                 bus.bit_mapper_ram_wdata,
                                                 bus.bit_mapper_ram_wen);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= bus_in_range ? mem[bus.bit_mapper_ram_addr] : '0;
    end
  end

  assign bus.bit_mapper_ram_rdata = rdata_q;

  // Lookup port
  logic                  accept;
  logic                  lk_in_range;
  logic [DATA_WIDTH-1:0] lk_word;
  logic [DATA_WIDTH-1:0] lk_data;

  logic                  p_valid_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic [TID_WIDTH-1:0]  p_tid_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [TID_WIDTH-1:0]  fifo_tid_q  [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  oob_q;

  logic                  push;
  logic                  pop;
  logic                  m_tvalid;
  logic [2:0]            occupancy;

  assign lk_in_range = {1'b0, bus.s_taddr} < DepthLim;

`ifdef DVBS2_BIT_MAPPER_RAM_WRITE_FWD_EN
  logic collision;
  assign collision = bus_wr && (bus.bit_mapper_ram_addr == bus.s_taddr);
  assign lk_word   = collision ? byte_merge(mem[bus.s_taddr], bus.bit_mapper_ram_wdata,
                                            bus.bit_mapper_ram_wen)
                               : mem[bus.s_taddr];
`else
  assign lk_word   = mem[bus.s_taddr];
`endif

  assign lk_data = lk_in_range ? lk_word : '0;

  assign m_tvalid  = (count_q != 2'd0);
  assign pop       = m_tvalid && bus.m_tready;
  // P never lands on a full FIFO: P plus FIFO never hold more than two words.
  assign push      = p_valid_q;
  assign occupancy = {1'b0, count_q} + {2'b00, p_valid_q};
  // A pop this cycle frees a slot, so a full pipeline still accepts while the
  // consumer drains; this keeps one response per cycle with m_tready high.
  assign bus.s_tready = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
  assign accept       = bus.s_tvalid && bus.s_tready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      p_tid_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tid_q[i]  <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      oob_q     <= 1'b0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_data_q <= lk_data;
        p_tid_q  <= bus.s_tid;
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= p_data_q;
        fifo_tid_q[wr_ptr_q]  <= p_tid_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (accept && !lk_in_range) begin
        oob_q <= 1'b1;
      end
    end
  end

  assign bus.m_tvalid = m_tvalid;
  assign bus.m_tdata  = fifo_data_q[rd_ptr_q];
  assign bus.m_tid    = fifo_tid_q[rd_ptr_q];
  assign oob_error    = oob_q;

endmodule

// File: tb/tb_dvbs2_bit_mapper_ram_responder.sv
module tb_dvbs2_bit_mapper_ram_responder;
  localparam int unsigned DEPTH = 240;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic oob_error;

  always #5 clk = ~clk;

  dvbs2_bit_mapper_ram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TID_WIDTH(TW)) bus_if ();

  dvbs2_bit_mapper_ram_responder #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TID_WIDTH(TW)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .bus(bus_if),
    .oob_error(oob_error)
  );

  typedef struct { int unsigned avail; logic [TW-1:0] tid; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tid; } req_t;
  typedef struct { int unsigned cyc; logic [TW-1:0] tid; logic [DW-1:0] data; } log_t;

  exp_t exp_q[$];   // responses owed by the DUT, oldest first
  req_t req_q[$];   // requests still to be offered on s_*
  log_t log_q[$];   // responses delivered (handshaken)

  logic [DW-1:0] shadow [256];
  bit            known  [256];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          tready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit          in_hs = 0;
  logic [DW-1:0] exp_rdata = '0;
  bit          exp_rdata_known = 1;
  logic        model_oob = 1'b0;

  // scratch for the compare process
  bit            ev, pop, bus_wr;
  logic [AW-1:0] a, la;
  logic [DW-1:0] d;
  logic [DW/8-1:0] wen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < DW / 8; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_oob       = 1'b0;
      exp_rdata       = '0;
      exp_rdata_known = 1;
      in_hs           = 0;
    end else begin
      if (exp_rdata_known) chk("bus_rdata", bus_if.bit_mapper_ram_rdata, exp_rdata);
      chk("oob_error", {31'b0, oob_error}, {31'b0, model_oob});
      ev  = exp_q.size() > 0 && exp_q[0].avail <= cyc;
      pop = ev && bus_if.m_tready;
      chk("m_tvalid", {31'b0, bus_if.m_tvalid}, {31'b0, ev});
      if (ev) begin
        chk("m_tdata", bus_if.m_tdata, exp_q[0].data);
        chk("m_tid", {28'b0, bus_if.m_tid}, {28'b0, exp_q[0].tid});
      end
      chk("s_tready", {31'b0, bus_if.s_tready},
          {31'b0, (exp_q.size() - int'(pop)) < 2});

      in_hs = bus_if.s_tvalid && bus_if.s_tready;
      if (pop) begin
        log_q.push_back('{cyc, exp_q[0].tid, exp_q[0].data});
        void'(exp_q.pop_front());
      end

      a      = bus_if.bit_mapper_ram_addr;
      wen    = bus_if.bit_mapper_ram_wen;
      bus_wr = (wen != '0) && (int'(a) < int'(DEPTH));
      if (in_hs) begin
        la = bus_if.s_taddr;
        if (int'(la) >= int'(DEPTH)) begin
          d = '0;
          model_oob = 1'b1;
        end else begin
          d = shadow[la];
`ifdef DVBS2_BIT_MAPPER_RAM_WRITE_FWD_EN
          if (bus_wr && a == la) d = merge(d, bus_if.bit_mapper_ram_wdata, wen);
`endif
        end
        exp_q.push_back('{cyc + 2, bus_if.s_tid, d});
      end

      exp_rdata_known = (int'(a) >= int'(DEPTH)) || known[a];
      exp_rdata       = (int'(a) < int'(DEPTH)) ? shadow[a] : '0;
      if (bus_wr) begin
        if (known[a]) begin
          shadow[a] = merge(shadow[a], bus_if.bit_mapper_ram_wdata, wen);
        end else if (wen == '1) begin
          shadow[a] = bus_if.bit_mapper_ram_wdata;
          known[a]  = 1;
        end
      end
    end
  end

  // Request driver and response back-pressure.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req_q.delete();
      bus_if.s_tvalid = 1'b0;
    end else begin
      if (in_hs && req_q.size() > 0) void'(req_q.pop_front());
      bus_if.s_tvalid = req_q.size() > 0;
      if (req_q.size() > 0) begin
        bus_if.s_taddr = req_q[0].addr;
        bus_if.s_tid   = req_q[0].tid;
      end
    end
    case (tready_mode)
      0:       bus_if.m_tready = 1'b1;
      1:       bus_if.m_tready = 1'($urandom_range(0, 1));
      default: bus_if.m_tready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_drive(input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                           input logic [DW/8-1:0] we);
    bus_if.bit_mapper_ram_addr  = ad;
    bus_if.bit_mapper_ram_wdata = wd;
    bus_if.bit_mapper_ram_wen   = we;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_pending", req_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    bus_drive('0, '0, '0);
    bus_if.s_tvalid = 1'b0;
    bus_if.s_taddr  = '0;
    bus_if.s_tid    = '0;
    bus_if.m_tready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_rdata", bus_if.bit_mapper_ram_rdata, 32'h0);
    chk("rst_m_tvalid", {31'b0, bus_if.m_tvalid}, 32'h0);
    chk("rst_m_tdata", bus_if.m_tdata, 32'h0);
    chk("rst_m_tid", {28'b0, bus_if.m_tid}, 32'h0);
    chk("rst_oob", {31'b0, oob_error}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_s_tready", {31'b0, bus_if.s_tready}, 32'h1);

    // Fill the table
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus_drive(AW'(i), (i == 5) ? 32'hA5A5_1234 : (i == 16) ? 32'h1111_1111 : $urandom, 4'hF);
      tick();
    end
    bus_drive(8'h05, '0, '0);
    tick();
    chk("read_0x05", bus_if.bit_mapper_ram_rdata, 32'hA5A5_1234);

    bus_drive(8'h05, 32'hFFFF_FFFF, 4'h2);
    tick();
    bus_drive(8'h05, '0, '0);
    tick();
    chk("byte_write_0x05", bus_if.bit_mapper_ram_rdata, 32'hA5A5_FF34);

    bus_drive(8'hF0, 32'hDEAD_BEEF, 4'hF);
    tick();
    bus_drive(8'hF0, '0, '0);
    tick();
    chk("oob_bus_read_0xF0", bus_if.bit_mapper_ram_rdata, 32'h0);

    // Streaming 0..15
    tready_mode = 0;
    log_q.delete();
    for (int i = 0; i < 16; i++) req_q.push_back('{AW'(i), TW'(i)});
    drain();
    chk("stream_count", log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      chk("stream_tid", {28'b0, log_q[i].tid}, i);
      chk("stream_no_bubble", log_q[i].cyc - log_q[0].cyc, i);
    end

    // Back-pressure
    tready_mode = 2;
    log_q.delete();
    for (int i = 0; i < 8; i++) req_q.push_back('{AW'(20 + i), TW'(i)});
    repeat (10) tick();
    chk("bp_s_tready", {31'b0, bus_if.s_tready}, 32'h0);
    chk("bp_accepted", 8 - req_q.size(), 2);
    chk("bp_held_tdata", bus_if.m_tdata, shadow[20]);
    tready_mode = 0;
    drain();
    chk("bp_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("bp_order", {28'b0, log_q[i].tid}, i);

    // Out-of-range lookup
    log_q.delete();
    req_q.push_back('{8'hEF, 4'h1});
    req_q.push_back('{8'hF3, 4'h2});
    drain();
    chk("oob_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("oob_inrange_data", log_q[0].data, shadow[8'hEF]);
      chk("oob_data_zero", log_q[1].data, 32'h0);
    end
    chk("oob_set", {31'b0, oob_error}, 32'h1);
    repeat (5) tick();
    chk("oob_sticky", {31'b0, oob_error}, 32'h1);

    // Collision at 0x10
    log_q.delete();
    req_q.push_back('{8'h10, 4'h5});
    tick();
    bus_drive(8'h10, 32'h2222_2222, 4'hF);
    tick();
    bus_drive(8'h10, '0, '0);
    drain();
    chk("coll_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
`ifdef DVBS2_BIT_MAPPER_RAM_WRITE_FWD_EN
      chk("coll_data", log_q[0].data, 32'h2222_2222);
`else
      chk("coll_data", log_q[0].data, 32'h1111_1111);
`endif
    end

    // Reset mid-stream
    tready_mode = 2;
    for (int i = 0; i < 4; i++) req_q.push_back('{AW'(30 + i), TW'(i)});
    repeat (4) tick();
    chk("pre_rst_m_tvalid", {31'b0, bus_if.m_tvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_tvalid", {31'b0, bus_if.m_tvalid}, 32'h0);
    chk("async_rst_oob", {31'b0, oob_error}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tready_mode = 0;
    tick();
    chk("post_rst_s_tready", {31'b0, bus_if.s_tready}, 32'h1);
    chk("post_rst_m_tvalid", {31'b0, bus_if.m_tvalid}, 32'h0);
    bus_drive(8'h10, '0, '0);
    tick();
    chk("table_survives_rst", bus_if.bit_mapper_ram_rdata, 32'h2222_2222);

    // Random traffic on both ports
    tready_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      if (req_q.size() < 4 && $urandom_range(0, 1) == 1)
        req_q.push_back('{AW'($urandom_range(0, 255)), TW'($urandom_range(0, 15))});
      bus_drive(AW'($urandom_range(0, 255)), $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
      tick();
    end
    bus_drive('0, '0, '0);
    tready_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
